// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that lets several packet sources share the write side
//   of one FIFO. A requester wins ownership for a burst that ends on its
//   'last' word, after MAX_BURST accepted words, or as soon as it drops req.
//   The releasing requester gets lowest priority for the next arbitration.
//
//   Optional feature: define FIFO_WRITE_ARBITER_STATS_EN to add stat_words,
//   per-requester 16-bit saturating counts of accepted words.
//
// Ports
//   write_clk      sole clock (FIFO write clock)
//   write_rst_n    synchronous active-low reset; also gates the write path
//   req/last/data  per-requester word-valid, end-of-packet, packed data
//   grant          registered one-hot owner indication
//   ack            per-requester word accepted this cycle
//   fifo_writable  FIFO has space
//   fifo_we        FIFO write enable
//   fifo_din       FIFO write data
//   stat_words     (stats build only) 16 bits per requester
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; arbitrate among req, no word accepted
// BURST | owner holds the FIFO; words accepted when req & writable

module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                     write_clk,
    input  logic                     write_rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     fifo_writable,
    output logic                     fifo_we,
    output logic [WIDTH-1:0]         fifo_din
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_words
`endif
);

    localparam int            IDX_W    = $clog2(NUM_REQ);
    localparam logic [7:0]    BEAT_MAX = 8'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   owner_q,  owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         beats_q,  beats_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;

    logic               owner_req;
    logic               owner_last;
    logic [WIDTH-1:0]   owner_data;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               accept;
    logic               release_burst;

    // Mux the owner's request, last flag and data slice.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req  = req[i];
                owner_last = last[i];
                owner_data = data[i*WIDTH +: WIDTH];
            end
        end
    end

    // First set req at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(idx);
            end
        end
    end

    // Write path is combinational on the owner and gated by reset so a
    // mid-burst reset stops writes in the same cycle.
    assign accept   = write_rst_n && (state_q == BURST) && owner_req && fifo_writable;
    assign fifo_we  = accept;
    assign fifo_din = (write_rst_n && (state_q == BURST)) ? owner_data : '0;
    assign grant    = grant_q;

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = accept && (owner_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        beats_d       = beats_q;
        grant_d       = grant_q;
        release_burst = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    beats_d = '0;
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    release_burst = 1'b1;
                end else if (accept) begin
                    beats_d = beats_q + 8'd1;
                    if (owner_last || (beats_q + 8'd1 == BEAT_MAX)) begin
                        release_burst = 1'b1;
                    end
                end
                if (release_burst) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (!write_rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beats_q  <= beats_d;
            grant_q  <= grant_d;
        end
    end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0] stat_q [NUM_REQ];
    logic [15:0] stat_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (ack[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge write_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!write_rst_n) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        stat_words = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_words[i*16 +: 16] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized + directed bench for fifo_write_arbiter. A transaction-level
// model (owner/pointer/beat integers) predicts per-cycle outputs and the
// stream of accepted words; a monitor pops and compares them.

module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic             write_clk = 1'b0;
    logic             write_rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     last;
    logic [N*W-1:0]   data;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic             fifo_writable;
    logic             fifo_we;
    logic [W-1:0]     fifo_din;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [N*16-1:0]  stat_words;
`endif

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .write_clk     (write_clk),
        .write_rst_n   (write_rst_n),
        .req           (req),
        .last          (last),
        .data          (data),
        .grant         (grant),
        .ack           (ack),
        .fifo_writable (fifo_writable),
        .fifo_we       (fifo_we),
        .fifo_din      (fifo_din)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        ,
        .stat_words    (stat_words)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] ack;
        logic         we;
        logic [W-1:0] din;
    } cyc_t;

    typedef struct {
        int           idx;
        logic [W-1:0] d;
    } word_t;

    cyc_t  cyc_q[$];
    word_t word_q[$];
    bit    mon_en = 1'b0;

    // Reference model: who owns the FIFO, where the pointer is, beats so far.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_beats = 0;
    int m_stat[N];

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic wr, input logic rst_n);
        cyc_t         e;
        word_t        w;
        bit           rel;
        bit           found;
        int           idx;
        logic [N-1:0] one;
        one = 1;
        rel = 1'b0;
        found = 1'b0;
        @(negedge write_clk);
        req           = r;
        last          = l;
        fifo_writable = wr;
        write_rst_n   = rst_n;
        for (int i = 0; i < N; i++) data[i*W +: W] = $urandom;
        e.grant = m_busy ? (one << m_owner) : '0;
        e.ack   = '0;
        e.we    = 1'b0;
        e.din   = '0;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_beats = 0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1;
                    m_owner = idx;
                    m_beats = 0;
                end
            end
        end else begin
            e.din = data[m_owner*W +: W];
            if (!r[m_owner]) begin
                rel = 1'b1;
            end else if (wr) begin
                e.we  = 1'b1;
                e.ack = one << m_owner;
                w.idx = m_owner;
                w.d   = e.din;
                word_q.push_back(w);
                m_beats++;
                if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
                if (l[m_owner] || m_beats == MB) rel = 1'b1;
            end
            if (rel) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        cyc_q.push_back(e);
    endtask

    // Monitor: samples mid-low-phase, compares the per-cycle expectation and,
    // whenever the DUT writes, the next expected word.
    initial begin
        cyc_t         e;
        word_t        w;
        logic [N-1:0] one;
        one = 1;
        forever begin
            @(negedge write_clk);
            #2;
            if (mon_en) begin
                checks++;
                if (cyc_q.size() == 0) begin
                    errors++;
                    $display("FAIL cycle_exp: no expectation queued at %0t", $time);
                end else begin
                    e = cyc_q.pop_front();
                    if (grant !== e.grant || ack !== e.ack || fifo_we !== e.we || fifo_din !== e.din) begin
                        errors++;
                        $display("FAIL cycle @%0t: got grant=%b ack=%b we=%b din=%h, want grant=%b ack=%b we=%b din=%h",
                                 $time, grant, ack, fifo_we, fifo_din, e.grant, e.ack, e.we, e.din);
                    end
                end
                if (fifo_we === 1'b1) begin
                    checks++;
                    if (word_q.size() == 0) begin
                        errors++;
                        $display("FAIL word @%0t: unexpected write din=%h ack=%b", $time, fifo_din, ack);
                    end else begin
                        w = word_q.pop_front();
                        if (fifo_din !== w.d || ack !== (one << w.idx)) begin
                            errors++;
                            $display("FAIL word @%0t: got din=%h ack=%b, want din=%h from req %0d",
                                     $time, fifo_din, ack, w.d, w.idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] r, l;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
        write_rst_n   = 1'b0;
        req           = '0;
        last          = '0;
        data          = '0;
        fifo_writable = 1'b1;
        repeat (3) @(posedge write_clk);
        mon_en = 1'b1;

        // Reset state held one more cycle, then release.
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Single requester: three words, last on the third.
        step(4'b0100, 4'b0000, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b1);
        step(4'b0100, 4'b0000, 1'b1, 1'b1);
        step(4'b0100, 4'b0100, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Round-robin with single-word packets on all requesters.
        repeat (12) step(4'b1111, 4'b1111, 1'b1, 1'b1);
        repeat (2)  step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Burst cap: requester 1 alone, no last.
        repeat (22) step(4'b0010, 4'b0000, 1'b1, 1'b1);
        repeat (2)  step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Backpressure mid-burst.
        repeat (3) step(4'b1000, 4'b0000, 1'b1, 1'b1);
        repeat (5) step(4'b1000, 4'b0000, 1'b0, 1'b1);
        repeat (3) step(4'b1000, 4'b0000, 1'b1, 1'b1);
        step(4'b1000, 4'b1000, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Reset after two of five words from requester 3.
        repeat (3) step(4'b1000, 4'b0000, 1'b1, 1'b1);
        step(4'b1001, 4'b0000, 1'b1, 1'b0);
        repeat (4) step(4'b1001, 4'b0000, 1'b1, 1'b1);
        step(4'b1001, 4'b0001, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b1, 1'b1);

        // Randomized traffic with occasional reset.
        repeat (3000) begin
            r = 4'($urandom);
            l = '0;
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
            step(r, l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
        end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
        step(4'b0000, 4'b0000, 1'b1, 1'b0);
        repeat (78800) step(4'b0001, 4'b0000, 1'b1, 1'b1);
`endif
        step(4'b0000, 4'b0000, 1'b1, 1'b1);
        #5;
        mon_en = 1'b0;

        checks++;
        if (cyc_q.size() != 0 || word_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d cycles and %0d words left unchecked, want 0 and 0",
                     cyc_q.size(), word_q.size());
        end
`ifdef FIFO_WRITE_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++;
            if (stat_words[i*16 +: 16] !== 16'(m_stat[i])) begin
                errors++;
                $display("FAIL stat_words[%0d]: got %0d, want %0d", i, stat_words[i*16 +: 16], m_stat[i]);
            end
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, data width matching the FIFO din/dout.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum words per grant (1..255).
REQ-004 SHALL have port write_clk, input, 1, sole clock; same clock as the FIFO write side.
REQ-005 SHALL have port write_rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port req, input, NUM_REQ, per-requester word-valid.
REQ-007 SHALL have port last, input, NUM_REQ, per-requester end-of-packet flag, qualified by req.
REQ-008 SHALL have port data, input, NUM_REQ*WIDTH, requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port grant, output, NUM_REQ, registered one-hot owner indication.
REQ-010 SHALL have port ack, output, NUM_REQ, word accepted this cycle.
REQ-011 SHALL have port fifo_writable, input, 1, FIFO space available.
REQ-012 SHALL have port fifo_we, output, 1, FIFO write enable.
REQ-013 SHALL have port fifo_din, output, WIDTH, FIFO write data.

Function
- REQ-014 SHALL implement a two-state machine: IDLE and BURST.
- REQ-015 SHALL, in IDLE with any req set, select the first set req at or after rr_ptr (wrapping modulo NUM_REQ), register it as owner, set grant one-hot and enter BURST; the grant latency from req is 1 cycle.
- REQ-016 SHALL keep grant all-zero and fifo_we=0 in IDLE; no word is accepted in IDLE.
- REQ-017 SHALL, in BURST, drive fifo_we = ack[owner] = req[owner] & fifo_writable, combinationally, in the same cycle.
- REQ-018 SHALL drive fifo_din = data slice of owner in BURST, and zero in IDLE.
- REQ-019 SHALL keep ack bits of non-owners at 0 at all times.
- REQ-020 SHALL count accepted words in an 8-bit beat counter, cleared on entry to BURST.
- REQ-021 SHALL leave BURST for IDLE after an accepted word with last[owner]=1, after the accepted word that brings beats to MAX_BURST, or in any cycle where req[owner]=0.
- REQ-022 SHALL stay in BURST while req[owner]=1 and fifo_writable=0, with no timeout and no beat increment.
- REQ-023 SHALL set rr_ptr to (owner+1) mod NUM_REQ on leaving BURST, so the releasing requester gets lowest priority next.
- REQ-024 SHALL clear grant in the cycle after release, with a minimum of 1 IDLE cycle between bursts.
- REQ-025 SHALL ignore req and last changes of non-owners during BURST.

Reset
- REQ-026 SHALL, when write_rst_n=0 at a write_clk edge, set state=IDLE, grant=0, rr_ptr=0, beats=0 and clear the owner.
- REQ-027 SHALL force fifo_we=0, ack=0 and fifo_din=0 combinationally while write_rst_n=0, including mid-burst.
- REQ-028 SHALL resume arbitration from requester 0 on the first edge after reset release.

Configuration
- REQ-029 SHALL, with macro FIFO_WRITE_ARBITER_STATS_EN defined, add output stat_words (NUM_REQ*16): per-requester 16-bit saturating counts of accepted words (hold at 65535), reset to 0 by write_rst_n.
- REQ-030 SHALL, with FIFO_WRITE_ARBITER_STATS_EN undefined, omit the stat_words port and its counters entirely; all other behaviour is identical.

Verification
- REQ-031 SHALL cover single requester: req[2]=1 for 3 words, last on the 3rd word, fifo_writable=1 -> grant=0100 after 1 cycle, 3 consecutive fifo_we pulses with data[2] values, then IDLE.
- REQ-032 SHALL cover round-robin: req=1111 held with last=1 on every word -> owners 0,1,2,3,0 in order, one word per burst.
- REQ-033 SHALL cover burst cap: MAX_BURST=8, req[1] held with no last -> exactly 8 acks, release, and requester 1 regranted after 1 IDLE cycle if it is the only requester.
- REQ-034 SHALL cover backpressure: fifo_writable=0 for 5 cycles mid-burst -> fifo_we=0, grant held, beat count unchanged, resumes on fifo_writable=1.
- REQ-035 SHALL cover reset mid-burst: write_rst_n=0 after 2 of 5 words of requester 3 -> fifo_we=0 immediately, grant=0; after release with req=1001, requester 0 is granted.
- REQ-036 SHALL cover stats: with FIFO_WRITE_ARBITER_STATS_EN, 70000 accepted words from requester 0 -> stat_words[15:0]=65535 and all other counts 0.
